// File: rtl/decoder_3x8.sv
// Registered 3-to-8 one-hot decoder with active-high enable and selectable output polarity.
// The output bus comes straight from flops, so downstream chip-selects never see glitches.
module decoder_3x8 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] A,
    input  logic       E,
    output logic [7:0] D
);

    logic [7:0] w_nxt;
    logic [7:0] r_dreg;

    always_comb begin
        w_nxt = 8'h00;
        if (E) begin
            w_nxt = 8'h01 << A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dreg <= 8'h00;
        end else begin
            r_dreg <= w_nxt;
        end
    end

    // Polarity is fixed at elaboration, so D is still a pure flop output (or its static inverse).
    generate
        if (OUT_ACTIVE_LOW) begin : g_active_low
            assign D = ~r_dreg;
        end else begin : g_active_high
            assign D = r_dreg;
        end
    endgenerate

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_dreg));

endmodule

// File: tb/tb_decoder_3x8.sv
// Directed-vector bench for decoder_3x8; drives both output polarities from the same stimulus.
// Inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
module tb_decoder_3x8;

    logic       clk;
    logic       rst_n;
    logic [2:0] A;
    logic       E;
    logic [7:0] dHigh;
    logic [7:0] dLow;

    int checkCount;
    int errorCount;

    logic [7:0] expTab [8];

    decoder_3x8 #(.OUT_ACTIVE_LOW(1'b0)) dutHigh (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .E    (E),
        .D    (dHigh)
    );

    decoder_3x8 #(.OUT_ACTIVE_LOW(1'b1)) dutLow (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .E    (E),
        .D    (dLow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic e);
        @(negedge clk);
        A = a;
        E = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        expTab[0] = 8'b00000001;
        expTab[1] = 8'b00000010;
        expTab[2] = 8'b00000100;
        expTab[3] = 8'b00001000;
        expTab[4] = 8'b00010000;
        expTab[5] = 8'b00100000;
        expTab[6] = 8'b01000000;
        expTab[7] = 8'b10000000;

        rst_n = 1'b1;
        A     = 3'b101;
        E     = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_high", dHigh, 8'h00);
        checkOutput("reset_low", dLow, 8'hFF);

        // Clock edges while reset is held must not load the enabled select.
        @(posedge clk);
        #1;
        checkOutput("reset_hold_high", dHigh, 8'h00);
        checkOutput("reset_hold_low", dLow, 8'hFF);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_high", dHigh, 8'b00100000);
        checkOutput("release_low", dLow, 8'b11011111);

        // Asynchronous reset mid-cycle, observed before the next rising edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_high", dHigh, 8'h00);
        checkOutput("async_reset_low", dLow, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 1'b0);
            checkOutput("disabled_high", dHigh, 8'h00);
            checkOutput("disabled_low", dLow, 8'hFF);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 1'b1);
            checkOutput("enabled_high", dHigh, expTab[i]);
            checkOutput("enabled_low", dLow, ~expTab[i]);
            checkOutput("onehot", 8'($countones(dHigh)), 8'd1);
        end

        applyStimulus(3'b011, 1'b1);
        checkOutput("toggle_on1", dHigh, 8'b00001000);
        applyStimulus(3'b011, 1'b0);
        checkOutput("toggle_off", dHigh, 8'b00000000);
        applyStimulus(3'b011, 1'b1);
        checkOutput("toggle_on2", dHigh, 8'b00001000);

        applyStimulus(3'b111, 1'b1);
        checkOutput("simul_before", dHigh, 8'b10000000);
        applyStimulus(3'b000, 1'b0);
        checkOutput("simul_after_high", dHigh, 8'h00);
        checkOutput("simul_after_low", dLow, 8'hFF);

        applyStimulus(3'b010, 1'b1);
        checkOutput("pol_sel_high", dHigh, 8'b00000100);
        checkOutput("pol_sel_low", dLow, 8'b11111011);
        applyStimulus(3'b010, 1'b1);
        checkOutput("hold_high", dHigh, 8'b00000100);

        // A changes between edges must not reach D until the next rising edge.
        @(negedge clk);
        A = 3'b110;
        #2;
        checkOutput("between_edges", dHigh, 8'b00000100);
        @(posedge clk);
        #1;
        checkOutput("after_edge", dHigh, 8'b01000000);

        applyStimulus(3'b010, 1'b0);
        checkOutput("pol_dis_low", dLow, 8'hFF);
        checkOutput("pol_dis_high", dHigh, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
